// File: rtl/car_light_seq.sv
// Tail-light sequencer: N lamps per side with fill/chase turn animation,
// hazard flash and steady brake. Outputs come straight from flops.
module car_light_seq #(
  parameter int N        = 3,
  parameter int STEP_DIV = 1,
  parameter int MODE     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         left,
  input  logic         right,
  input  logic         E,
  input  logic         brake,
  output logic [N-1:0] light_left,
  output logic [N-1:0] light_right,
  output logic [1:0]   state
);

  localparam int PH_W = $clog2(N + 1);
  localparam int PC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LEFT  = 2'b01;
  localparam logic [1:0] S_RIGHT = 2'b10;
  localparam logic [1:0] S_HAZ   = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            tick;
  logic [N-1:0]    pat, brake_fill, haz_fill;
  logic [N-1:0]    light_left_q, light_left_d;
  logic [N-1:0]    light_right_q, light_right_d;

  always_comb begin
    if (E || (left && right)) state_d = S_HAZ;
    else if (left)            state_d = S_LEFT;
    else if (right)           state_d = S_RIGHT;
    else                      state_d = S_IDLE;
  end

  assign tick = (pc_q == PC_W'(STEP_DIV - 1));

  // A state change restarts both counters so the first step is a full STEP_DIV.
  always_comb begin
    pc_d = tick ? '0 : pc_q + PC_W'(1);
    ph_d = ph_q;
    if (state_d != state_q) begin
      pc_d = '0;
      ph_d = (state_d == S_IDLE) ? '0 : PH_W'(1);
    end else if (tick) begin
      case (state_q)
        S_LEFT, S_RIGHT: ph_d = (ph_q == PH_W'(N)) ? '0 : ph_q + PH_W'(1);
        S_HAZ:           ph_d = (ph_q == PH_W'(1)) ? '0 : PH_W'(1);
        default:         ph_d = '0;
      endcase
    end
  end

  // Pattern is built from the next phase so outputs line up with the state flops.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pat
      if (MODE == 0) begin : g_fill
        assign pat[gi] = (ph_d > PH_W'(gi));
      end else begin : g_chase
        assign pat[gi] = (ph_d == PH_W'(gi + 1));
      end
    end
  endgenerate

  assign brake_fill = {N{brake}};
  assign haz_fill   = {N{ph_d == PH_W'(1)}};

  always_comb begin
    light_left_d  = brake_fill;
    light_right_d = brake_fill;
    case (state_d)
      S_LEFT:  light_left_d  = pat;
      S_RIGHT: light_right_d = pat;
      S_HAZ: begin
        light_left_d  = haz_fill;
        light_right_d = haz_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      pc_q          <= '0;
      light_left_q  <= '0;
      light_right_q <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      pc_q          <= pc_d;
      light_left_q  <= light_left_d;
      light_right_q <= light_right_d;
    end
  end

  assign light_left  = light_left_q;
  assign light_right = light_right_q;
  assign state       = state_q;

endmodule

// File: tb/tb_car_light_seq.sv
// Drives four differently parameterised sequencers with shared stimulus and
// compares every cycle against a step-count based reference model.
module tb_car_light_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, left, right, E, brake;

  logic [2:0] ll0, lr0;
  logic [3:0] ll1, lr1;
  logic [2:0] ll2, lr2;
  logic [7:0] ll3, lr3;
  logic [1:0] st0, st1, st2, st3;

  car_light_seq #(.N(3), .STEP_DIV(1), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .E(E), .brake(brake),
    .light_left(ll0), .light_right(lr0), .state(st0));
  car_light_seq #(.N(4), .STEP_DIV(1), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .E(E), .brake(brake),
    .light_left(ll1), .light_right(lr1), .state(st1));
  car_light_seq #(.N(3), .STEP_DIV(3), .MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .E(E), .brake(brake),
    .light_left(ll2), .light_right(lr2), .state(st2));
  car_light_seq #(.N(8), .STEP_DIV(2), .MODE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .E(E), .brake(brake),
    .light_left(ll3), .light_right(lr3), .state(st3));

  int p_n[4]    = '{3, 4, 3, 8};
  int p_sd[4]   = '{1, 1, 3, 2};
  int p_mode[4] = '{0, 1, 0, 1};

  int n_vec = 0;
  int n_err = 0;

  // Model: current mode (0 idle,1 left,2 right,3 hazard) and cycles spent in it.
  int   m_mode = 0;
  int   m_age  = 0;
  logic m_rst  = 1'b1;
  logic m_brake = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int turn_pat(input int n, input int mode, input int p);
    if (p == 0) return 0;
    if (mode == 0) return (1 << p) - 1;
    return 1 << (p - 1);
  endfunction

  function automatic logic [7:0] exp_side(input int i, input int side);
    int mask, k, p;
    mask = (1 << p_n[i]) - 1;
    if (m_rst) return 8'h00;
    k = m_age / p_sd[i];
    case (m_mode)
      1: begin
        p = (1 + k) % (p_n[i] + 1);
        return 8'((side == 0) ? turn_pat(p_n[i], p_mode[i], p) : (m_brake ? mask : 0));
      end
      2: begin
        p = (1 + k) % (p_n[i] + 1);
        return 8'((side == 1) ? turn_pat(p_n[i], p_mode[i], p) : (m_brake ? mask : 0));
      end
      3: return 8'(((k % 2) == 0) ? mask : 0);
      default: return 8'(m_brake ? mask : 0);
    endcase
  endfunction

  task automatic model_edge();
    int nm;
    if (!rst_n) begin
      m_rst = 1'b1; m_mode = 0; m_age = 0;
    end else begin
      if (E || (left && right)) nm = 3;
      else if (left)            nm = 1;
      else if (right)           nm = 2;
      else                      nm = 0;
      m_age = (nm == m_mode && !m_rst) ? m_age + 1 : 0;
      if (m_rst && nm != 0) m_age = 0;
      m_mode = nm;
      m_rst  = 1'b0;
    end
    m_brake = brake;
  endtask

  task automatic step(input string label);
    logic [7:0] gl[4], gr[4];
    logic [1:0] gs[4];
    @(posedge clk);
    model_edge();
    #1;
    gl[0] = {5'b0, ll0}; gr[0] = {5'b0, lr0}; gs[0] = st0;
    gl[1] = {4'b0, ll1}; gr[1] = {4'b0, lr1}; gs[1] = st1;
    gl[2] = {5'b0, ll2}; gr[2] = {5'b0, lr2}; gs[2] = st2;
    gl[3] = ll3;         gr[3] = lr3;         gs[3] = st3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d.state", i), {6'b0, gs[i]}, m_rst ? 8'h00 : 8'(m_mode));
      check($sformatf("d%0d.left", i),  gl[i], exp_side(i, 0));
      check($sformatf("d%0d.right", i), gr[i], exp_side(i, 1));
    end
    $display("%-8s rst_n=%b l=%b r=%b E=%b brk=%b | st=%b L=%b R=%b",
             label, rst_n, left, right, E, brake, st0, ll0, lr0);
  endtask

  task automatic drive(input logic rn, input logic l, input logic r,
                       input logic e, input logic b, input int cycles, input string label);
    rst_n = rn; left = l; right = r; E = e; brake = b;
    for (int c = 0; c < cycles; c++) step(label);
  endtask

  initial begin
    rst_n = 1'b0; left = 1'b1; right = 1'b0; E = 1'b1; brake = 1'b1;
    step("reset");
    step("reset");
    drive(1, 1, 0, 0, 0, 8, "left");
    drive(1, 0, 0, 0, 0, 1, "idle");
    drive(1, 0, 1, 0, 0, 5, "right");
    drive(1, 0, 0, 0, 0, 1, "idle");
    drive(1, 0, 0, 1, 0, 6, "haz");
    drive(1, 0, 0, 1, 1, 6, "haz_brk");
    drive(1, 0, 0, 0, 0, 1, "idle");
    drive(1, 1, 0, 0, 1, 2, "left_brk");
    drive(1, 0, 1, 0, 1, 3, "swap_r");
    drive(1, 1, 1, 0, 0, 4, "l+r");
    drive(1, 0, 1, 0, 0, 3, "right");
    drive(1, 0, 0, 0, 1, 1, "brake");
    drive(1, 1, 0, 0, 1, 3, "left_brk");
    drive(0, 1, 0, 0, 1, 1, "reset");
    drive(1, 1, 0, 0, 1, 4, "left_brk");
    drive(1, 0, 0, 0, 0, 1, "idle");
    drive(1, 1, 0, 0, 0, 1, "left");
    drive(1, 0, 0, 0, 0, 1, "idle");
    drive(1, 1, 0, 0, 0, 2, "re_left");

    for (int t = 0; t < 300; t++) begin
      drive(($urandom_range(0, 40) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 0),
            $urandom_range(1, 12), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
